// File: rtl/tx_fsrc_hole_gen_pkg.sv
// tx_fsrc_hole_gen_pkg: shared FSM state type and width helpers for the FSRC hole generator.
package tx_fsrc_hole_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int NUM_WORDS_DEF   = 8;
  localparam int ACCUM_WIDTH_DEF = 32;
  localparam int EXT_WIDTH       = ACCUM_WIDTH_DEF + $clog2(NUM_WORDS_DEF + 1);
  // Width holding acc + NUM_WORDS*step without overflow for a given configuration.
  function automatic int ext_width(input int aw, input int nw);
    return aw + $clog2(nw + 1);
  endfunction
endpackage

// File: rtl/tx_fsrc_hole_pattern.sv
// tx_fsrc_hole_pattern: combinational per-beat hole mask and hole count from accumulator and step.
//   acc   - accumulator value at the start of the beat
//   step  - per-word phase increment
//   holes - bit k set when word k carries out of the accumulator
//   count - number of set bits in holes
module tx_fsrc_hole_pattern
  import tx_fsrc_hole_gen_pkg::*;
#(
  parameter int NUM_WORDS   = 8,
  parameter int ACCUM_WIDTH = 32
) (
  input  logic [ACCUM_WIDTH-1:0]         acc,
  input  logic [ACCUM_WIDTH-1:0]         step,
  output logic [NUM_WORDS-1:0]           holes,
  output logic [$clog2(NUM_WORDS+1)-1:0] count
);
  localparam int EW = ext_width(ACCUM_WIDTH, NUM_WORDS);
  localparam int PW = $clog2(NUM_WORDS + 1);
  logic [EW-1:0]             s;
  logic [EW-ACCUM_WIDTH-1:0] c, c_prev;
  // A hole is a change in the integer part of the extended running sum.
  always_comb begin
    holes  = '0;
    count  = '0;
    s      = '0;
    c      = '0;
    c_prev = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      s        = EW'(acc) + EW'(k + 1) * EW'(step);
      c        = s[EW-1:ACCUM_WIDTH];
      holes[k] = c != c_prev;
      count    = count + PW'(c != c_prev);
      c_prev   = c;
    end
  end
endmodule

// File: rtl/tx_fsrc_hole_gen.sv
// tx_fsrc_hole_gen: phase-accumulator hole mask stream generator for the TX FSRC hole-insertion stage.
//   clk, reset            - clock, asynchronous active-high reset
//   enable                - level start/keep-running request
//   step, phase_init      - increment and initial phase, sampled when leaving IDLE
//   holes_valid/ready     - beat handshake towards the hole-insertion stage
//   holes_data            - per-word hole mask, bit 0 earliest
//   active                - high while running or draining
//   hole_count            - saturating count of hole words emitted since start
module tx_fsrc_hole_gen
  import tx_fsrc_hole_gen_pkg::*;
#(
  parameter int NUM_WORDS   = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ACCUM_WIDTH-1:0] step,
  input  logic [ACCUM_WIDTH-1:0] phase_init,
  output logic                   holes_valid,
  input  logic                   holes_ready,
  output logic [NUM_WORDS-1:0]   holes_data,
  output logic                   active,
  output logic [CNT_WIDTH-1:0]   hole_count
);
  localparam int PW = $clog2(NUM_WORDS + 1);
  state_t                 state;
  logic [ACCUM_WIDTH-1:0] acc, step_q;
  logic [NUM_WORDS-1:0]   pat;
  logic [PW-1:0]          pat_n;
  logic [CNT_WIDTH:0]     cnt_sum;
  tx_fsrc_hole_pattern #(.NUM_WORDS(NUM_WORDS), .ACCUM_WIDTH(ACCUM_WIDTH)) u_pattern (
    .acc  (acc),
    .step (step_q),
    .holes(pat),
    .count(pat_n)
  );
  // One extra bit exposes overflow so the counter can saturate.
  assign cnt_sum = {1'b0, hole_count} + (CNT_WIDTH+1)'(pat_n);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      step_q      <= '0;
      holes_valid <= 1'b0;
      holes_data  <= '0;
      active      <= 1'b0;
      hole_count  <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          step_q     <= step;
          acc        <= phase_init;
          hole_count <= '0;
          active     <= 1'b1;
          state      <= RUN;
        end
        // A beat accepted on the same edge that enable drops must not linger into DRAIN.
        RUN: if (!enable) begin
          state <= DRAIN;
          if (holes_ready) holes_valid <= 1'b0;
        end else if (!holes_valid || holes_ready) begin
          holes_data  <= pat;
          holes_valid <= 1'b1;
          acc         <= acc + step_q * ACCUM_WIDTH'(NUM_WORDS);
          hole_count  <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
        DRAIN: if (!holes_valid || holes_ready) begin
          holes_valid <= 1'b0;
          active      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_fsrc_hole_gen.sv
// tb_tx_fsrc_hole_gen: randomized and directed checks of the hole generator against a word-index phase model.
module tb_tx_fsrc_hole_gen;
  logic       clk = 0, reset = 1, enable = 0, holes_ready = 0;
  logic [7:0] step = 0, phase_init = 0;
  logic       holes_valid, active;
  logic [7:0] holes_data, hole_count;
  longint     p0, st;
  int         acc_n, tests, fails;

  tx_fsrc_hole_gen #(.NUM_WORDS(8), .ACCUM_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step), .phase_init(phase_init),
    .holes_valid(holes_valid), .holes_ready(holes_ready), .holes_data(holes_data),
    .active(active), .hole_count(hole_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word w of the run is a hole when the ideal phase p0+w*st crosses a multiple of 256 on that word.
  function automatic logic [7:0] beat(input int b);
    logic [7:0] m;
    for (int k = 0; k < 8; k++) begin
      longint w = 8 * b + k;
      m[k] = ((p0 + (w + 1) * st) >> 8) != ((p0 + w * st) >> 8);
    end
    return m;
  endfunction

  function automatic int exp_count(input int n);
    int s = 0;
    for (int b = 0; b < n; b++) s += $countones(beat(b));
    return s > 255 ? 255 : s;
  endfunction

  // Every beat generated is either accepted or the one currently presented.
  task automatic cyc(input logic rdy, input logic en);
    holes_ready = rdy;
    enable = en;
    if (holes_valid && rdy) acc_n++;
    @(negedge clk);
    if (holes_valid) check("data", {56'd0, holes_data}, beat(acc_n));
    check("count", {56'd0, hole_count}, exp_count(acc_n + int'(holes_valid)));
  endtask

  task automatic start(input logic [7:0] s, input logic [7:0] p);
    step = s;
    phase_init = p;
    st = s;
    p0 = p;
    acc_n = 0;
    cyc(1, 1);
    check("start_active", active, 1);
    check("start_valid_lo", holes_valid, 0);
    cyc(1, 1);
    check("start_valid_hi", holes_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && active; i++) cyc(1'($urandom_range(0, 1)), 0);
    check("drain_done", active, 0);
    check("drain_valid", holes_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", holes_valid, 0);
    check("rst_active", active, 0);
    check("rst_count", {56'd0, hole_count}, 0);
    check("rst_data", {56'd0, holes_data}, 0);
    reset = 0;
    start(0, 0);
    repeat (10) cyc(1, 1);
    check("zero_data", {56'd0, holes_data}, 8'h00);
    check("zero_count", {56'd0, hole_count}, 0);
    drain();
    start(128, 0);
    check("aa_first", {56'd0, holes_data}, 8'hAA);
    check("aa_count1", {56'd0, hole_count}, 4);
    repeat (2) cyc(1, 1);
    check("aa_count3", {56'd0, hole_count}, 12);
    drain();
    start(64, 192);
    check("h11_first", {56'd0, holes_data}, 8'h11);
    repeat (6) cyc(1, 1);
    check("h11_later", {56'd0, holes_data}, 8'h11);
    drain();
    start(128, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1);
      check("stall_valid", holes_valid, 1);
      check("stall_data", {56'd0, holes_data}, 8'hAA);
      check("stall_count", {56'd0, hole_count}, 4);
    end
    repeat (3) cyc(1, 1);
    check("resume_count", {56'd0, hole_count}, 16);
    cyc(0, 1);
    cyc(0, 0);
    check("drop_valid", holes_valid, 1);
    check("drop_active", active, 1);
    cyc(0, 0);
    cyc(1, 0);
    check("drop_xfer_valid", holes_valid, 0);
    check("drop_xfer_active", active, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      check("idle_valid", holes_valid, 0);
    end
    start(64, 192);
    repeat (4) cyc(1, 1);
    cyc(0, 1);
    cyc(0, 0);
    step = 255;
    phase_init = 0;
    cyc(0, 1);
    check("drain_ignore_en", active, 1);
    check("drain_hold", holes_valid, 1);
    cyc(1, 1);
    check("drain_end_valid", holes_valid, 0);
    check("drain_end_active", active, 0);
    start(255, 0);
    repeat (40) cyc(1, 1);
    check("sat_count", {56'd0, hole_count}, 255);
    drain();
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(5, 40);
      start(8'($urandom), 8'($urandom));
      for (int i = 0; i < n; i++) begin
        step = 8'($urandom);
        phase_init = 8'($urandom);
        cyc(1'($urandom_range(0, 3) != 0), 1);
      end
      drain();
    end
    start(128, 0);
    repeat (3) cyc(1, 1);
    #3 reset = 1;
    #1;
    check("arst_valid", holes_valid, 0);
    check("arst_active", active, 0);
    check("arst_count", {56'd0, hole_count}, 0);
    step = 64;
    phase_init = 192;
    repeat (2) @(negedge clk);
    reset = 0;
    start(64, 192);
    check("arst_restart", {56'd0, holes_data}, 8'h11);
    repeat (4) cyc(1, 1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
